// File: rtl/axis_uart_tx_if.sv
// AXI4-Stream word channel feeding the UART transmitter.
// The producer drives tdata/tvalid; the transmitter returns tready.
interface axis_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_tx.sv
// axis_uart_tx: AXI4-Stream sink that serializes each accepted word as a
// UART frame: start bit, LSB-first data, optional even parity, one stop bit.
// Every bit lasts max(prescale,1) clk cycles, using the prescale value
// captured at the handshake. All outputs come straight from registers.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit
// between the last data bit and the stop bit.
module axis_uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      nrst,
    axis_uart_tx_if.slave             input_axis,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      txd,
    output logic                      busy
);
    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [IDX_W-1:0]          IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]          IDX_ONE  = IDX_W'(1);
    localparam logic [PRESCALE_WIDTH-1:0] P_ONE    = PRESCALE_WIDTH'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [PRESCALE_WIDTH-1:0] period_q, period_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      txd_q, txd_d;
    logic                      busy_q, busy_d;
    logic                      tready_q, tready_d;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    logic                      handshake;
    logic                      bit_end;
    logic [PRESCALE_WIDTH-1:0] p_eff;

    // tready_q is only ever high in IDLE, so this is the accept condition.
    assign handshake = tready_q & input_axis.tvalid;
    assign bit_end   = (cnt_q == '0);
    assign p_eff     = (prescale == '0) ? P_ONE : prescale;

    assign input_axis.tready = tready_q;
    assign txd               = txd_q;
    assign busy              = busy_q;

    // State and datapath registers; reset abandons any frame and idles the line high.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            period_q <= P_ONE;
            cnt_q    <= '0;
            idx_q    <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            tready_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            tready_q <= tready_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state: advance one frame section each time a bit period expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (handshake) state_d = S_START;
            S_START:  if (bit_end) state_d = S_DATA;
            S_DATA: begin
                if (bit_end && (idx_q == IDX_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_end) state_d = S_STOP;
`endif
            S_STOP:   if (bit_end) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath: capture the word on accept, then emit one bit per period.
    always_comb begin
        shift_d  = shift_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        tready_d = tready_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        // Bit-period counter runs only while a frame is on the line.
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? (period_q - P_ONE) : (cnt_q - P_ONE);
        end
        case (state_q)
            S_IDLE: begin
                tready_d = 1'b1;
                txd_d    = 1'b1;
                busy_d   = 1'b0;
                if (handshake) begin
                    shift_d  = input_axis.tdata;
                    period_d = p_eff;
                    cnt_d    = p_eff - P_ONE;
                    txd_d    = 1'b0;
                    busy_d   = 1'b1;
                    tready_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^input_axis.tdata;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    txd_d = shift_q[0];
                    idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        txd_d = parity_q;
`else
                        txd_d = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        txd_d   = shift_d[0];
                        idx_d   = idx_q + IDX_ONE;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) txd_d = 1'b1;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    txd_d    = 1'b1;
                    busy_d   = 1'b0;
                    tready_d = 1'b1;
                end
            end
            default: begin
                txd_d    = 1'b1;
                busy_d   = 1'b0;
                tready_d = 1'b0;
            end
        endcase
    end
endmodule
